// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - ISA field layout, opcode constants and hazard FSM encoding
// Shared by the hazard controller and anything else that decodes instruction words.
package cpu_isa_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;

  localparam logic [4:0] RTYPE = 5'b00000;
  localparam logic [4:0] BNE   = 5'b00010;
  localparam logic [4:0] JR    = 5'b00100;
  localparam logic [4:0] BLT   = 5'b00110;
  localparam logic [4:0] SW    = 5'b00111;
  localparam logic [4:0] LW    = 5'b01000;

  localparam logic [4:0] MUL   = 5'b00110;
  localparam logic [4:0] DIV   = 5'b00111;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

  function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [4:0] ir_rd(input logic [31:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] ir_rs(input logic [31:0] ir);
    return ir[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] ir_rt(input logic [31:0] ir);
    return ir[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [4:0] ir_alu(input logic [31:0] ir);
    return ir[ALU_MSB:ALU_LSB];
  endfunction

  function automatic logic is_muldiv(input logic [31:0] ir);
    return (ir_opcode(ir) == RTYPE) &&
           ((ir_alu(ir) == MUL) || (ir_alu(ir) == DIV));
  endfunction

  // Store data (sw's rd) is deliberately not a source here: it is bypassed from M/W.
  function automatic logic reads_reg(input logic [31:0] ir, input logic [4:0] r);
    logic [4:0] op;
    logic       rs_hit;
    logic       rt_hit;
    logic       rd_hit;
    op     = ir_opcode(ir);
    rs_hit = (op != JR) && (ir_rs(ir) == r);
    rt_hit = (op == RTYPE) && (ir_rt(ir) == r);
    rd_hit = ((op == BNE) || (op == BLT) || (op == JR)) && (ir_rd(ir) == r);
    return rs_hit || rt_hit || rd_hit;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating 32-bit event counter with synchronous clear
// Clear takes priority over a same-cycle increment.
module hazard_perf_cnt (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / redirect / multdiv stall and flush controller
// Optional perf counters (stall, flush, multdiv wait) under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import cpu_isa_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] IR_FD,
  input  logic [31:0] IR_DX,
  input  logic        dx_valid,
  input  logic        redirect,
  input  logic        md_ready,
  output logic        pc_we,
  output logic        fd_we,
  output logic        dx_we,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        xm_bubble,
  output logic        md_start,
  output logic        md_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] md_cnt
`endif
);

  localparam logic [7:0] TMO_LAST = 8'(MD_TIMEOUT - 1);

  hz_state_e  state_q;
  hz_state_e  state_d;
  logic [7:0] tmo_q;
  logic [7:0] tmo_d;
  logic       md_err_q;
  logic       md_err_d;

  logic       dx_is_lw;
  logic       load_use;
  logic       dx_muldiv;
  logic       unused_ir;

  assign dx_is_lw  = dx_valid && (ir_opcode(IR_DX) == LW) && (ir_rd(IR_DX) != 5'd0);
  assign load_use  = dx_is_lw && reads_reg(IR_FD, ir_rd(IR_DX));
  assign dx_muldiv = dx_valid && is_muldiv(IR_DX);
  assign unused_ir = ^{IR_FD[11:0], IR_DX[21:7], IR_DX[1:0]};

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    md_err_d  = md_err_q;
    pc_we     = 1'b1;
    fd_we     = 1'b1;
    dx_we     = 1'b1;
    fd_flush  = 1'b0;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    md_start  = 1'b0;

    case (state_q)
      RUN: begin
        // md_ready is ignored here; a redirect squashes any pending hazard.
        if (redirect) begin
          fd_flush  = 1'b1;
          dx_bubble = 1'b1;
        end else if (dx_muldiv) begin
          md_start  = 1'b1;
          pc_we     = 1'b0;
          fd_we     = 1'b0;
          dx_we     = 1'b0;
          xm_bubble = 1'b1;
          tmo_d     = '0;
          state_d   = MD_WAIT;
        end else if (load_use) begin
          pc_we     = 1'b0;
          fd_we     = 1'b0;
          dx_bubble = 1'b1;
        end
      end

      MD_WAIT: begin
        if (md_ready) begin
          state_d = RUN;
        end else if (tmo_q == TMO_LAST) begin
          // Abort: drop the mul/div from X and D/X, let fetch resume.
          md_err_d  = 1'b1;
          xm_bubble = 1'b1;
          dx_bubble = 1'b1;
          state_d   = RUN;
        end else begin
          pc_we     = 1'b0;
          fd_we     = 1'b0;
          dx_we     = 1'b0;
          xm_bubble = 1'b1;
          tmo_d     = tmo_q + 8'd1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      tmo_q    <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      md_err_q <= md_err_d;
    end
  end

  assign md_err = md_err_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (perf_clr),
    .inc     (~pc_we),
    .cnt     (stall_cnt)
  );

  hazard_perf_cnt u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (perf_clr),
    .inc     (fd_flush),
    .cnt     (flush_cnt)
  );

  hazard_perf_cnt u_md_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (perf_clr),
    .inc     (state_q == MD_WAIT),
    .cnt     (md_cnt)
  );
`endif

endmodule
